// File: rtl/uart_rx_byte_if.sv
// Receive-side bundle from the UART byte receiver to the register-bank command decoder.
// The receiver drives every signal; the decoder only observes.
interface uart_rx_byte_if;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err_out;
    logic       busy_out;

    modport master (output data_out, output valid_out, output frame_err_out, output busy_out);
    modport slave  (input  data_out, input  valid_out, input  frame_err_out, input  busy_out);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversamples rx_in and strobes each byte or framing error for one cycle.
// Pulse appears one clock after the stop-bit sample, about 9.5 bit times after the start edge; there is no backpressure.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 142
) (
    input  logic           clk_in,
    input  logic           rst_in_n,
    input  logic           rx_in,
    uart_rx_byte_if.master rx_bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);

    logic          rx_m, rx_s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          valid_q, valid_nxt;
    logic          err_q, err_nxt;
    logic          tick;

    // Synchronizer idles high so reset release never fakes a falling edge.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
        end
    end

    assign tick = (cnt == '0);

    // Counter runs down to zero; the edge at which it reads zero is the sample edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = tick ? cnt : cnt - 1'b1;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_LD;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = rx_s ? IDLE : DATA;
                    cnt_nxt   = BIT_LD;
                    idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_nxt = BIT_LD;
                    idx_nxt = idx + 3'd1;
                    if (idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_nxt = shift;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (state == DATA && tick) shift_nxt = {rx_s, shift[7:1]};
        // A bad stop bit leaves the last good byte in place.
        if (state == STOP && tick) begin
            if (rx_s) begin
                data_nxt  = shift;
                valid_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    assign rx_bus.data_out      = data_q;
    assign rx_bus.valid_out     = valid_q;
    assign rx_bus.frame_err_out = err_q;
    assign rx_bus.busy_out      = (state != IDLE);

endmodule
